// File: rtl/fp_addsub_pipe.sv
// Pipelined floating-point adder/subtractor: operand capture, align, add and
// normalise/round stages under one global advance, with tag and exception sideband.
module fp_addsub_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 sub,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] res,
  output logic [TAG_W-1:0]     out_tag,
  output logic                 exception
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int MW = EXP_W + MAN_W;
  localparam int XW = MAN_W + 4;
  localparam int EW = EXP_W + 2;
  localparam int LW = $clog2(XW + 1);
  localparam logic [EW-1:0] EXP_ONES = {2'b00, {EXP_W{1'b1}}};

  logic advance;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // Operand capture
  logic             v0;
  logic             sub0;
  logic [W-1:0]     a0;
  logic [W-1:0]     b0;
  logic [TAG_W-1:0] tag0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v0   <= 1'b0;
      sub0 <= 1'b0;
      a0   <= '0;
      b0   <= '0;
      tag0 <= '0;
    end else if (advance) begin
      v0 <= in_valid;
      if (in_valid) begin
        sub0 <= sub;
        a0   <= a;
        b0   <= b;
        tag0 <= in_tag;
      end
    end
  end

  // Align: zero/denormal operands become exact zero, larger magnitude goes first
  logic [EXP_W-1:0] exp_a;
  logic [EXP_W-1:0] exp_b;
  logic [EXP_W-1:0] big_exp;
  logic [EXP_W-1:0] small_exp;
  logic [EXP_W-1:0] exp_diff;
  logic [MW-1:0]    mag_a;
  logic [MW-1:0]    mag_b;
  logic [MW-1:0]    big_mag;
  logic [MW-1:0]    small_mag;
  logic             sign_a;
  logic             sign_b;
  logic             big_sign;
  logic             small_sign;
  logic             special;
  logic [XW-1:0]    big_sig;
  logic [XW-1:0]    small_sig;
  logic [XW-1:0]    small_aligned;
  logic [2*XW-1:0]  small_wide;

  always_comb begin
    exp_a   = a0[W-2:MAN_W];
    exp_b   = b0[W-2:MAN_W];
    special = (&exp_a) || (&exp_b);
    mag_a   = (exp_a == '0) ? '0 : a0[MW-1:0];
    mag_b   = (exp_b == '0) ? '0 : b0[MW-1:0];
    sign_a  = a0[W-1];
    sign_b  = b0[W-1] ^ sub0;
    if (mag_b > mag_a) begin
      big_mag    = mag_b;
      big_sign   = sign_b;
      small_mag  = mag_a;
      small_sign = sign_a;
    end else begin
      big_mag    = mag_a;
      big_sign   = sign_a;
      small_mag  = mag_b;
      small_sign = sign_b;
    end
    big_exp    = big_mag[MW-1:MAN_W];
    small_exp  = small_mag[MW-1:MAN_W];
    exp_diff   = big_exp - small_exp;
    big_sig    = {(big_exp != '0), big_mag[MAN_W-1:0], 3'b000};
    small_sig  = {(small_exp != '0), small_mag[MAN_W-1:0], 3'b000};
    small_wide = {small_sig, {XW{1'b0}}} >> exp_diff;
    if (int'(exp_diff) >= MAN_W + 3)
      small_aligned = {{(XW-1){1'b0}}, |small_sig};
    else
      small_aligned = small_wide[2*XW-1:XW] | {{(XW-1){1'b0}}, |small_wide[XW-1:0]};
  end

  logic             v1;
  logic [TAG_W-1:0] tag1;
  logic             exc1;
  logic             sign1;
  logic             eff_sub1;
  logic [EXP_W-1:0] exp1;
  logic [XW-1:0]    big1;
  logic [XW-1:0]    small1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v1       <= 1'b0;
      tag1     <= '0;
      exc1     <= 1'b0;
      sign1    <= 1'b0;
      eff_sub1 <= 1'b0;
      exp1     <= '0;
      big1     <= '0;
      small1   <= '0;
    end else if (advance) begin
      v1       <= v0;
      tag1     <= tag0;
      exc1     <= special;
      sign1    <= big_sign;
      eff_sub1 <= big_sign ^ small_sign;
      exp1     <= big_exp;
      big1     <= big_sig;
      small1   <= small_aligned;
    end
  end

  // Add: the big operand never loses to the small one, so the difference stays non-negative
  logic [XW:0] sum_c;

  always_comb begin
    if (eff_sub1)
      sum_c = {1'b0, big1} - {1'b0, small1};
    else
      sum_c = {1'b0, big1} + {1'b0, small1};
  end

  logic             v2;
  logic [TAG_W-1:0] tag2;
  logic             exc2;
  logic             sign2;
  logic [EXP_W-1:0] exp2;
  logic [XW:0]      sum2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v2    <= 1'b0;
      tag2  <= '0;
      exc2  <= 1'b0;
      sign2 <= 1'b0;
      exp2  <= '0;
      sum2  <= '0;
    end else if (advance) begin
      v2    <= v1;
      tag2  <= tag1;
      exc2  <= exc1;
      sign2 <= (sum_c == '0) ? 1'b0 : sign1;
      exp2  <= exp1;
      sum2  <= sum_c;
    end
  end

  // Normalise and round; exponent kept two bits wider so underflow shows as sign
  logic [LW-1:0]    lzc;
  logic [XW-1:0]    norm;
  logic [EW-1:0]    exp_n;
  logic [EW-1:0]    exp_r;
  logic             round_up;
  logic             mant_ovf;
  logic             overflow;
  logic             underflow;
  logic [MAN_W+1:0] mant_r;
  logic [MAN_W-1:0] man_out;
  logic [W-1:0]     res_c;
  logic             exc_c;

  always_comb begin
    lzc = '0;
    for (int i = 0; i < XW; i++) begin
      if (sum2[i])
        lzc = LW'(XW - 1 - i);
    end
    if (sum2[XW]) begin
      norm  = {sum2[XW:2], sum2[1] | sum2[0]};
      exp_n = {2'b00, exp2} + EW'(1);
    end else begin
      norm  = sum2[XW-1:0] << lzc;
      exp_n = {2'b00, exp2} - EW'(lzc);
    end
    round_up  = norm[2] && (norm[1] || norm[0] || norm[3]);
    mant_r    = {1'b0, norm[XW-1:3]} + (MAN_W+2)'(round_up);
    mant_ovf  = mant_r[MAN_W+1];
    exp_r     = exp_n + EW'(mant_ovf);
    man_out   = mant_ovf ? mant_r[MAN_W:1] : mant_r[MAN_W-1:0];
    underflow = exp_r[EW-1] || (exp_r == '0);
    overflow  = !exp_r[EW-1] && (exp_r >= EXP_ONES);
    res_c     = '0;
    exc_c     = 1'b0;
    if (exc2)
      exc_c = 1'b1;
    else if ((sum2 == '0) || underflow)
      res_c = '0;
    else if (overflow)
      exc_c = 1'b1;
    else
      res_c = {sign2, exp_r[EXP_W-1:0], man_out};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      res       <= '0;
      out_tag   <= '0;
      exception <= 1'b0;
    end else if (advance) begin
      out_valid <= v2;
      res       <= v2 ? res_c : '0;
      out_tag   <= v2 ? tag2 : '0;
      exception <= v2 && exc_c;
    end
  end

endmodule
